// File: rtl/fuzz_top.sv
// fuzz_top: registered mixed-arithmetic datapath.
// Folds four operand words into one 541-bit flopped status vector.
module fuzz_top (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [17:0]  wire3,
    input  logic [20:0]  wire2,
    input  logic [12:0]  wire1,
    input  logic [19:0]  wire0,
    output logic [540:0] y
);

    logic [71:0]  vec_c;
    logic [21:0]  sum_c;
    logic [33:0]  w1x, w2x, prod_c;
    logic signed [20:0] w1e;
    logic [19:0]  w3e, mn_c;
    logic         gt_c;
    logic [20:0]  mx_c;
    logic [51:0]  ma_c;
    logic [37:0]  pbits;
    logic [5:0]   pop_c;

    // vec_q doubles as the [71:0] field, the change-detect
    // reference and the first stage of the two-cycle delay.
    logic [71:0]  vec_q, d2_q, chg_q;
    logic [21:0]  sum_q;
    logic [33:0]  prod_q, prod_d_q;
    logic [19:0]  xr_q, mn_q;
    logic [31:0]  acc_q;
    logic         neg_q, gt_q, eq_q, par_q;
    logic [63:0]  sr_q;
    logic [20:0]  mx_q;
    logic [15:0]  cnt_q;
    logic [51:0]  ma_q;
    logic [5:0]   pop_q;

    assign vec_c  = {wire3, wire2, wire1, wire0};
    assign sum_c  = {{9{wire1[12]}}, wire1} + {wire2[20], wire2};
    assign w1x    = {{21{wire1[12]}}, wire1};
    assign w2x    = {{13{wire2[20]}}, wire2};
    assign prod_c = w1x * w2x;
    assign w1e    = {{8{wire1[12]}}, wire1};
    assign gt_c   = $signed(wire2) > w1e;
    assign mx_c   = gt_c ? wire2 : w1e;
    assign w3e    = {2'b00, wire3};
    assign mn_c   = (wire0 < w3e) ? wire0 : w3e;
    assign ma_c   = {20'd0, acc_q} * {32'd0, wire0};
    assign pbits  = {wire0, wire3};

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < 38; i++)
            pop_c = pop_c + {5'd0, pbits[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            d2_q     <= '0;
            chg_q    <= '0;
            sum_q    <= '0;
            prod_q   <= '0;
            prod_d_q <= '0;
            xr_q     <= '0;
            mn_q     <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            par_q    <= 1'b0;
            sr_q     <= '0;
            mx_q     <= '0;
            cnt_q    <= '0;
            ma_q     <= '0;
            pop_q    <= '0;
        end else begin
            vec_q    <= vec_c;
            d2_q     <= vec_q;
            chg_q    <= vec_c ^ vec_q;
            sum_q    <= sum_c;
            prod_q   <= prod_c;
            prod_d_q <= prod_q;
            xr_q     <= wire0 ^ w3e;
            mn_q     <= mn_c;
            acc_q    <= acc_q + {12'd0, wire0};
            neg_q    <= wire1[12];
            gt_q     <= gt_c;
            eq_q     <= (wire0 == w3e);
            par_q    <= ^wire3;
            sr_q     <= {sr_q[62:0], ^vec_c};
            mx_q     <= mx_c;
            cnt_q    <= cnt_q + 16'd1;
            ma_q     <= ma_c;
            pop_q    <= pop_c;
        end
    end

    assign y = {pop_q, chg_q, ma_q, d2_q, mn_q, cnt_q, mx_q,
                sr_q, prod_d_q, par_q, eq_q, gt_q, neg_q,
                acc_q, xr_q, prod_q, sum_q, vec_q};

endmodule

// File: tb/tb_fuzz_top.sv
// tb_fuzz_top: directed plus random stimulus for fuzz_top,
// checked against an arithmetic reference model.
module tb_fuzz_top;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [17:0]  wire3;
    logic [20:0]  wire2;
    logic [12:0]  wire1;
    logic [19:0]  wire0;
    logic [540:0] y;

    int total = 0;
    int bad = 0;

    logic [71:0]  h1;
    logic [31:0]  macc;
    logic [63:0]  msr;
    logic [15:0]  mcnt;
    logic [540:0] exp_y;
    logic [71:0]  va, vb;

    always #5 clk = ~clk;

    fuzz_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wire3 (wire3),
        .wire2 (wire2),
        .wire1 (wire1),
        .wire0 (wire0),
        .y     (y)
    );

    task automatic chk(input string tag, input logic [540:0] obs,
                       input logic [540:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [71:0] rnd72();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[71:0];
    endfunction

    // Expected y after an edge that samples v; p is the previous
    // edge's sample, aold the running sum before this edge.
    function automatic logic [540:0] model(
        input logic [71:0] v, input logic [71:0] p,
        input logic [31:0] aold, input logic [63:0] srn,
        input logic [15:0] cntn);
        logic [19:0] w0;
        logic [17:0] w3;
        logic signed [12:0] sw1, pw1;
        logic signed [20:0] sw2, pw2;
        longint s1, s2, q1, q2;
        logic [21:0] sum;
        logic [33:0] prod, pprod;
        logic [20:0] mx;
        logic [19:0] mn;
        logic [51:0] ma;
        logic [63:0] big;
        logic [5:0] pop;
        logic gt, neg, eq;
        w0  = v[19:0];
        sw1 = v[32:20];
        sw2 = v[53:33];
        w3  = v[71:54];
        pw1 = p[32:20];
        pw2 = p[53:33];
        s1 = sw1; s2 = sw2; q1 = pw1; q2 = pw2;
        sum   = 22'(s1 + s2);
        prod  = 34'(s1 * s2);
        pprod = 34'(q1 * q2);
        mx    = 21'((s1 > s2) ? s1 : s2);
        gt    = s2 > s1;
        neg   = s1 < 0;
        eq    = int'(w0) == int'(w3);
        mn    = (int'(w0) < int'(w3)) ? w0 : 20'(w3);
        big   = 64'(aold) * 64'(w0);
        ma    = big[51:0];
        pop   = 6'($countones({w0, w3}));
        return {pop, v ^ p, ma, p, mn, cntn, mx, srn, pprod,
                ^w3, eq, gt, neg, aold + 32'(w0),
                w0 ^ {2'b00, w3}, prod, sum, v};
    endfunction

    task automatic model_reset();
        h1 = '0; macc = '0; msr = '0; mcnt = '0;
    endtask

    // Entered and left on a falling edge.
    task automatic step(input logic [71:0] v, input string tag);
        {wire3, wire2, wire1, wire0} = v;
        @(posedge clk);
        msr   = {msr[62:0], ^v};
        mcnt  = mcnt + 16'd1;
        exp_y = model(v, h1, macc, msr, mcnt);
        macc  = macc + 32'(v[19:0]);
        h1    = v;
        #1 chk(tag, y, exp_y);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {wire3, wire2, wire1, wire0} = rnd72();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        {wire3, wire2, wire1, wire0} = rnd72();
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            {wire3, wire2, wire1, wire0} = rnd72();
            #1 chk("reset_hold", y, '0);
        end
        @(negedge clk);
        {wire3, wire2, wire1, wire0} = '0;
        rst_n = 1'b1;
        model_reset();

        step('0, "first_edge");
        chk("first_cnt", y[318:303], 16'd1);

        step({18'd0, 21'h000005, 13'h1FFF, 20'd0}, "signed");
        chk("signed_sum", y[93:72], 22'd4);
        chk("signed_prod", y[127:94], 34'h3FFFFFFFB);
        chk("signed_max", y[302:282], 21'd5);
        chk("signed_neg", y[180], 1'b1);
        chk("signed_gt", y[181], 1'b1);

        step({18'h0003F, 21'd0, 13'd0, 20'h0003F}, "pop");
        chk("pop_eq", y[182], 1'b1);
        chk("pop_min", y[338:319], 20'h0003F);
        chk("pop_xor", y[147:128], 20'd0);
        chk("pop_cnt", y[540:535], 6'd12);
        chk("pop_par", y[183], 1'b0);

        step({18'd77, 21'h1FFF00, 13'h1F00, 20'd9}, "eq_signed");
        step({18'd5, 21'h000123, 13'h0123, 20'd5}, "eq_signed2");
        chk("eq_gt", y[181], 1'b0);
        chk("eq_max", y[302:282], 21'h000123);

        va = rnd72();
        vb = rnd72();
        step(va, "dly_a");
        step(vb, "dly_b1");
        chk("dly_a_out", y[410:339], va);
        chk("chg_ab", y[534:463], va ^ vb);
        step(vb, "dly_b2");
        chk("chg_zero", y[534:463], 72'd0);
        chk("dly_b_out", y[410:339], vb);

        repeat (200) step(rnd72(), "rand");

        #2 rst_n = 1'b0;
        #1 chk("async_clr", y, '0);
        @(posedge clk);
        #1 chk("async_hold", y, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        va = rnd72();
        step(va, "post_rst1");
        chk("post_rst_cnt", y[318:303], 16'd1);
        chk("post_rst_d2", y[410:339], 72'd0);
        chk("post_rst_chg", y[534:463], va);
        repeat (50) step(rnd72(), "rand2");

        do_reset();
        repeat (4097) step({52'd0, 20'hFFFFF}, "acc");
        chk("acc_wrap", y[179:148], 32'h000FEFFF);
        chk("acc_cnt", y[318:303], 16'h1001);
        repeat (61439) step(rnd72(), "cnt_run");
        chk("cnt_wrap", y[318:303], 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
